// File: rtl/inst_encoder_pkg.sv
// Shared opcodes, instruction formats and the NOP word for the RV32I instruction encoder.
package inst_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SH,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U,
    FMT_BAD
  } fmt_e;

endpackage

// File: rtl/inst_encoder_imm_extract.sv
// Combinational immediate extraction from an encoded RV32I word, chosen by its opcode.
// Shift-immediates decode as plain I-type here; the encoder excludes them from comparison.
module imm_extract
  import inst_enc_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (word[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{word[31]}}, word[31:20]};
      OP_STORE:                 imm = {{20{word[31]}}, word[31:25], word[11:7]};
      OP_BRANCH:                imm = {{19{word[31]}}, word[31], word[7], word[30:25],
                                       word[11:8], 1'b0};
      OP_JAL:                   imm = {{11{word[31]}}, word[31], word[19:12], word[20],
                                       word[30:21], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {word[31:12], 12'b0};
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Single-stage RV32I instruction encoder with valid/ready on both sides and a handshake counter.
// Optional INST_ENC_SELFCHECK_EN re-extracts the immediate and flags mismatches on selfcheck_fail.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = NOP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             err,
  output logic [CNT_W-1:0] enc_count
`ifdef INST_ENC_SELFCHECK_EN
  ,
  output logic             selfcheck_fail
`endif
);

  // Handshake: a transfer happens on a clk edge where valid && ready. The producer keeps
  // its payload stable until that edge; in_ready is combinational so a full register
  // drains and refills in the same cycle when out_ready is high.
  logic             out_valid_q, out_valid_d;
  logic [31:0]      inst_q, inst_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;

  logic             accept;
  logic             out_hs;
  fmt_e             fmt;
  logic [31:0]      enc_word;
  logic             enc_err;
  logic             sext_ok_11;
  logic             sext_ok_12;
  logic             sext_ok_20;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign inst      = inst_q;
  assign err       = err_q;
  assign enc_count = enc_count_q;

  assign sext_ok_11 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign sext_ok_12 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign sext_ok_20 = (imm[31:20] == '0) || (imm[31:20] == '1);

  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      OP_R:                fmt = FMT_R;
      OP_IMM:              fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
      OP_LOAD, OP_JALR:    fmt = FMT_I;
      OP_STORE:            fmt = FMT_S;
      OP_BRANCH:           fmt = FMT_B;
      OP_JAL:              fmt = FMT_J;
      OP_LUI, OP_AUIPC:    fmt = FMT_U;
      default:             fmt = FMT_BAD;
    endcase
  end

  // Out-of-range immediates still emit their truncated encoding, only err is raised.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b1;
    case (fmt)
      FMT_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err  = 1'b0;
      end
      FMT_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = !sext_ok_11;
      end
      FMT_SH: begin
        enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        enc_err  = |imm[31:5];
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !sext_ok_11;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = !sext_ok_12 || imm[0];
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = !sext_ok_20 || imm[0];
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = |imm[11:0];
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    err_d       = err_q;
    enc_count_d = enc_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      inst_d      = enc_word;
      err_d       = enc_err;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (out_hs) begin
      enc_count_d = enc_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      err_q       <= 1'b0;
      enc_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
      enc_count_q <= enc_count_d;
    end
  end

`ifdef INST_ENC_SELFCHECK_EN
  logic [31:0] chk_imm;
  logic [31:0] exp_imm;
  logic        chk_en;
  logic        selfcheck_fail_q, selfcheck_fail_d;

  imm_extract u_imm_extract (
    .word (enc_word),
    .imm  (chk_imm)
  );

  // Only formats whose immediate round-trips exactly are compared; R and shifts carry none.
  always_comb begin
    exp_imm = '0;
    chk_en  = 1'b0;
    case (fmt)
      FMT_I, FMT_S: begin
        exp_imm = {{20{imm[11]}}, imm[11:0]};
        chk_en  = 1'b1;
      end
      FMT_B: begin
        exp_imm = {{19{imm[12]}}, imm[12:0]};
        chk_en  = 1'b1;
      end
      FMT_J: begin
        exp_imm = {{11{imm[20]}}, imm[20:0]};
        chk_en  = 1'b1;
      end
      FMT_U: begin
        exp_imm = {imm[31:12], 12'b0};
        chk_en  = 1'b1;
      end
      default: begin
        exp_imm = '0;
        chk_en  = 1'b0;
      end
    endcase
    if (enc_err) begin
      chk_en = 1'b0;
    end
    selfcheck_fail_d = selfcheck_fail_q || (accept && chk_en && (chk_imm != exp_imm));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      selfcheck_fail_q <= 1'b0;
    end else begin
      selfcheck_fail_q <= selfcheck_fail_d;
    end
  end

  assign selfcheck_fail = selfcheck_fail_q;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, range errors, back-pressure, counter and reset.
module tb_inst_encoder;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      inst;
  logic             err;
  logic [CNT_W-1:0] enc_count;
`ifdef INST_ENC_SELFCHECK_EN
  logic             selfcheck_fail;
`endif

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [32:0]      exp_q[$];
  logic [32:0]      exp_item;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             pending = 1'b0;

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .err       (err),
    .enc_count (enc_count)
`ifdef INST_ENC_SELFCHECK_EN
    ,
    .selfcheck_fail (selfcheck_fail)
`endif
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                            input logic [4:0] rs2_i, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm_i);
    opcode = op;
    rd     = rd_i;
    rs1    = rs1_i;
    rs2    = rs2_i;
    funct3 = f3;
    funct7 = f7;
    imm    = imm_i;
  endtask

  // One field set with out_ready high; a word still held from the previous call drains
  // on the same edge, so the bench counter advances for it.
  task automatic drive_one(input string tag, input logic [6:0] op, input logic [4:0] rd_i,
                           input logic [4:0] rs1_i, input logic [4:0] rs2_i, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm_i,
                           input logic [31:0] exp_inst, input logic exp_err);
    @(negedge clk);
    set_fields(op, rd_i, rs1_i, rs2_i, f3, f7, imm_i);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back({exp_err, exp_inst});
    #1;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (pending) exp_cnt++;
    pending  = 1'b1;
    exp_item = exp_q.pop_front();
    check({tag, "_inst"}, inst, exp_item[31:0]);
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_item[32]});
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_count"}, {16'b0, enc_count}, {16'b0, exp_cnt});
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_fields('0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_count", {16'b0, enc_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    drive_one("addi",     7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5,          32'h00500093, 1'b0);
    drive_one("sw",       7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'h00, 32'd8,          32'h0021A423, 1'b0);
    drive_one("beq",      7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFFFFFC,   32'hFE208EE3, 1'b0);
    drive_one("jal",      7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048,       32'h001000EF, 1'b0);
    drive_one("addi_oor", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048,       32'h80000093, 1'b1);
    drive_one("bad_op",   7'h7F,      5'd1, 5'd2, 5'd3, 3'b000, 7'h00, 32'd0,          32'h00000013, 1'b1);
    drive_one("add",      7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'hDEADBEEF,   32'h002081B3, 1'b0);
    drive_one("slli",     7'b0010011, 5'd1, 5'd2, 5'd0, 3'b001, 7'h00, 32'd3,          32'h00311093, 1'b0);
    drive_one("srai",     7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'h20, 32'd3,          32'h40315093, 1'b0);
    drive_one("slli_oor", 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b001, 7'h00, 32'd32,         32'h00011093, 1'b1);
    drive_one("lui",      7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h12345000,   32'h123452B7, 1'b0);
    drive_one("lui_oor",  7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h12345001,   32'h123452B7, 1'b1);
    drive_one("beq_odd",  7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3,          32'h00000163, 1'b1);
    drive_one("jal_odd",  7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1,          32'h000000EF, 1'b1);

    // drain the last word
    @(posedge clk);
    #1;
    exp_cnt++;
    pending = 1'b0;
    check("drain_valid", {31'b0, out_valid}, 32'd0);
    check("drain_count", {16'b0, enc_count}, {16'b0, exp_cnt});

    // back-pressure: word A held for three cycles while word B waits
    @(negedge clk);
    set_fields(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("stall_a_valid", {31'b0, out_valid}, 32'd1);
    check("stall_a_inst", inst, 32'h00100113);
    @(negedge clk);
    set_fields(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h12345000);
    #1;
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_hold_inst", inst, 32'h00100113);
      check("stall_hold_ready", {31'b0, in_ready}, 32'd0);
      check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
      check("stall_hold_count", {16'b0, enc_count}, {16'b0, exp_cnt});
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_cnt++;
    check("release_b_inst", inst, 32'h123452B7);
    check("release_b_valid", {31'b0, out_valid}, 32'd1);
    check("release_count1", {16'b0, enc_count}, {16'b0, exp_cnt});
    @(posedge clk);
    #1;
    exp_cnt++;
    check("release_empty", {31'b0, out_valid}, 32'd0);
    check("release_count2", {16'b0, enc_count}, {16'b0, exp_cnt});

    // reset while a word is held
    @(negedge clk);
    set_fields(7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'h00, 32'd8);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("midrst_pre_valid", {31'b0, out_valid}, 32'd1);
    check("midrst_pre_inst", inst, 32'h0021A423);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_count", {16'b0, enc_count}, 32'd0);
    check("midrst_inst", inst, 32'd0);
    check("midrst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Assembles 32-bit RV32I instruction words from decoded fields (opcode, registers, funct, immediate). It performs the inverse of the register-file/immediate-extraction path.
Used by the switch/UART program loader and by the test harness to build instruction memory contents at run time.
Single-stage pipelined encoder with valid/ready handshakes on both sides, immediate range checking and an output counter.

Parameters:
CNT_W, 16, width of the encoded-instruction counter
NOP_WORD, 32'h00000013, word emitted for unsupported opcodes (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
in_valid  in  1  field set valid
in_ready  out  1  encoder can accept a field set
opcode  in  7  RV32I major opcode
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R-type, shift-immediates)
imm  in  32  immediate as a signed byte offset/value
out_valid  out  1  inst valid
out_ready  in  1  consumer accepts inst
inst  out  32  encoded instruction
err  out  1  immediate not representable or opcode unsupported; qualified by out_valid
enc_count  out  CNT_W  number of completed output handshakes

Behaviour:
- Reset: rst is synchronous, active-low, on clk. While rst=0 at a clk edge: out_valid=0, inst=0, err=0, enc_count=0.
- Reset mid-transfer drops any held word. No output handshake counts in that cycle.
- in_ready = !out_valid || out_ready (combinational). Input accept = in_valid && in_ready.
- On accept, the encoded word is registered into inst/err and out_valid=1 next cycle. Latency is 1 cycle.
- Full throughput when out_ready=1.
- Simultaneous output handshake and new accept: the new word replaces the old one with no bubble.
- Output handshake without an accept: out_valid=0 next cycle.
- inst/err hold stable while out_valid=1 && out_ready=0.
- enc_count increments by 1 per output handshake (out_valid && out_ready) and wraps modulo 2^CNT_W.
- Encoding by opcode:
  - R 0110011: funct7|rs2|rs1|funct3|rd|op. imm ignored.
  - I 0010011/0000011/1100111: imm[11:0]|rs1|funct3|rd|op.
  - Shift-immediate (0010011, funct3=001/101): funct7|imm[4:0]|rs1|funct3|rd|op.
  - S 0100011: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B 1100011: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - J 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - U 0110111/0010111: imm[31:12]|rd|op.
- Range checks; failure sets err=1 but the truncated encoding is still emitted:
  - I/S: imm[31:11] all equal.
  - Shift-immediate: imm[31:5]==0.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
- Unsupported opcode: inst=NOP_WORD, err=1.

Optional Feature:
INST_ENC_SELFCHECK_EN:
- Defined: an imm_extract instance re-derives the sign-extended immediate from the encoded word.
- A mismatch against the sign-extended low bits of imm (error-free formats only) sets sticky output selfcheck_fail, cleared only by reset.
- Undefined: no instance and no selfcheck_fail port.

Decomposition:
- Package inst_enc_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - format enum {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD};
  - NOP constant.
- Sub-module imm_extract: combinational opcode-based immediate extraction, used only under INST_ENC_SELFCHECK_EN.
- Format decode and range checks stay inline.

Test Plan:
- addi: op=0010011, rd=1, rs1=0, f3=0, imm=5 -> inst=0x00500093, err=0, one cycle after accept.
- sw: op=0100011, rs1=3, rs2=2, f3=010, imm=8 -> 0x0021A423.
- beq: op=1100011, rs1=1, rs2=2, f3=0, imm=-4 -> 0xFE208EE3.
- jal: op=1101111, rd=1, imm=2048 -> 0x001000EF.
- Out-of-range addi: op=0010011, rd=1, imm=2048 -> 0x80000093 with err=1.
- Unsupported opcode 0x7F -> 0x00000013 with err=1.
- Back-to-back with out_ready held 0 for 3 cycles:
  - in_ready=0 and inst stable throughout;
  - on release, the second word appears the next cycle and enc_count advances 1 per handshake;
  - rst=0 asserted while out_valid=1 -> out_valid=0, enc_count=0 next cycle.
